mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 185 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register pair, a small
// transmit FIFO and a registered serial shifter with back-to-back framing.
module mmio_uart_tx #(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  data_in,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [15:0] data_out,
    output logic        data_out_en,
    output logic        tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   COUNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [15:0]      STATUS_ADDR = BASE_ADDR + 16'd1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------
    logic sel_data, sel_status;
    logic push_req, status_rd;

    assign sel_data  = (address == BASE_ADDR);
    assign sel_status = (address == STATUS_ADDR);
    assign push_req  = mem_write && sel_data;
    assign status_rd = mem_read && sel_status;

    // ---------------------------------------------------------------
    // Transmit FIFO
    // ---------------------------------------------------------------
    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0] count;
    logic           empty, full;
    logic           pop, push, drop;
    logic           overflow;

    assign empty = (count == '0);
    assign full  = (count == COUNT_FULL);
    // A pop at the same edge frees a slot, so a push into a full FIFO is
    // still accepted then.
    assign push  = push_req && (!full || pop);
    assign drop  = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new drop outranks the read-to-clear.
            if (drop)
                overflow <= 1'b1;
            else if (status_rd)
                overflow <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Serial FSM
    // ---------------------------------------------------------------
    state_t         state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]     bit_idx, bit_idx_next;
    logic [7:0]     shift_reg, shift_next;
    logic           tx_next;
    logic           busy;
    logic           bit_done;

    assign busy     = (state != IDLE);
    assign bit_done = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
            tx        <= tx_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = bit_done ? '0 : cnt + 1'b1;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        tx_next      = tx;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                tx_next  = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr];
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                    tx_next      = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        tx_next      = shift_reg[bit_idx + 3'd1];
                    end
                end
            end
            STOP: begin
                // Chain straight into the next START to avoid an idle gap.
                if (bit_done) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_mem[rd_ptr];
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Read data path
    // ---------------------------------------------------------------
    always_comb begin
        data_out    = 16'h0000;
        data_out_en = 1'b0;
        if (status_rd) begin
            data_out_en = 1'b1;
            data_out    = {12'b0, overflow, busy, empty, full};
        end else if (mem_read && sel_data) begin
            data_out_en = 1'b1;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  data_in = 8'h00;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] data_out;
    logic        data_out_en;
    logic        tx;

    int total = 0;
    int bad = 0;

    mmio_uart_tx #(
        .BASE_ADDR(16'hFF00),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .data_in(data_in),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .data_out(data_out),
        .data_out_en(data_out_en),
        .tx(tx)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic wait_slot();
        @(posedge clk);
        #1;
    endtask

    // Expected line level k cycles after a frame of byte b has started.
    function automatic logic exp_tx(input logic [7:0] b, input int k);
        int i;
        i = k / CPB;
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        return 1'b1;
    endfunction

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        total++;
        if (tx !== 1'b1) begin
            bad++; $display("FAIL reset_tx got=%b want=1", tx);
        end
        address = 16'hFF01; mem_read = 1'b1;
        #1;
        total++;
        if (data_out !== 16'h0002 || data_out_en !== 1'b1) begin
            bad++; $display("FAIL reset_status got=%h/%b want=0002/1", data_out, data_out_en);
        end
        mem_read = 1'b0;
        repeat (3) wait_slot();
        reset = 1'b0;
        wait_slot();
    endtask

    task automatic test_decode();
        address = 16'hFF01; mem_read = 1'b1;
        #1;
        total++;
        if (data_out !== 16'h0002 || data_out_en !== 1'b1) begin
            bad++; $display("FAIL status_idle got=%h/%b want=0002/1", data_out, data_out_en);
        end
        address = 16'hFF02;
        #1;
        total++;
        if (data_out !== 16'h0000 || data_out_en !== 1'b0) begin
            bad++; $display("FAIL read_other got=%h/%b want=0000/0", data_out, data_out_en);
        end
        address = 16'hFF00;
        #1;
        total++;
        if (data_out !== 16'h0000 || data_out_en !== 1'b1) begin
            bad++; $display("FAIL read_txdata got=%h/%b want=0000/1", data_out, data_out_en);
        end
        // Writes to STATUS or unmapped addresses must not start a frame.
        mem_read = 1'b0; mem_write = 1'b1; data_in = 8'h00; address = 16'hFF01;
        wait_slot();
        address = 16'hFF02;
        wait_slot();
        mem_write = 1'b0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (tx !== 1'b1) begin
                bad++; $display("FAIL ignored_write_tx cyc=%0d got=%b want=1", i, tx);
            end
            wait_slot();
        end
        address = 16'hFF01; mem_read = 1'b1;
        #1;
        total++;
        if (data_out !== 16'h0002) begin
            bad++; $display("FAIL ignored_write_status got=%h want=0002", data_out);
        end
        mem_read = 1'b0;
    endtask

    task automatic test_frame(input logic [7:0] b);
        address = 16'hFF00; data_in = b; mem_write = 1'b1;
        wait_slot();
        mem_write = 1'b0;
        total++;
        if (tx !== 1'b1) begin
            bad++; $display("FAIL frame_push_edge_tx got=%b want=1", tx);
        end
        address = 16'hFF01; mem_read = 1'b1;
        #1;
        total++;
        if (data_out !== 16'h0000) begin
            bad++; $display("FAIL frame_queued_status got=%h want=0000", data_out);
        end
        for (int k = 0; k < FRAME; k++) begin
            wait_slot();
            total++;
            if (tx !== exp_tx(b, k) || data_out[2] !== 1'b1) begin
                bad++; $display("FAIL frame_bit k=%0d tx=%b busy=%b want tx=%b busy=1", k, tx, data_out[2], exp_tx(b, k));
            end
        end
        wait_slot();
        total++;
        if (tx !== 1'b1 || data_out !== 16'h0002) begin
            bad++; $display("FAIL frame_end tx=%b status=%h want 1/0002", tx, data_out);
        end
        mem_read = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [5];
        for (int i = 0; i < 5; i++) bytes[i] = 8'(i + 1);
        address = 16'hFF00; mem_write = 1'b1; mem_read = 1'b1; data_in = bytes[0];
        #1;
        total++;
        if (data_out !== 16'h0000 || data_out_en !== 1'b1) begin
            bad++; $display("FAIL rw_same_cycle got=%h/%b want=0000/1", data_out, data_out_en);
        end
        for (int i = 0; i < 5; i++) begin
            data_in = bytes[i];
            wait_slot();
            mem_read = 1'b0;
        end
        mem_write = 1'b0;
        // Three frame cycles have elapsed; four bytes still queued.
        address = 16'hFF01; mem_read = 1'b1;
        #1;
        total++;
        if (data_out !== 16'h0005) begin
            bad++; $display("FAIL b2b_full_status got=%h want=0005", data_out);
        end
        mem_read = 1'b0;
        for (int g = 3; g < 5 * FRAME; g++) begin
            total++;
            if (tx !== exp_tx(bytes[g / FRAME], g % FRAME)) begin
                bad++; $display("FAIL b2b_tx g=%0d got=%b want=%b", g, tx, exp_tx(bytes[g / FRAME], g % FRAME));
            end
            wait_slot();
        end
        mem_read = 1'b1;
        #1;
        total++;
        if (tx !== 1'b1 || data_out !== 16'h0002) begin
            bad++; $display("FAIL b2b_end tx=%b status=%h want 1/0002", tx, data_out);
        end
        mem_read = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] bytes [6];
        for (int i = 0; i < 6; i++) bytes[i] = 8'(8'h11 * (i + 1));
        address = 16'hFF00; mem_write = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in = bytes[i];
            wait_slot();
        end
        mem_write = 1'b0;
        // 8'h66 was dropped; a frame is in flight, so busy is also set.
        address = 16'hFF01; mem_read = 1'b1;
        #1;
        total++;
        if (data_out !== 16'h000D) begin
            bad++; $display("FAIL ovf_status got=%h want=000D", data_out);
        end
        wait_slot();
        total++;
        if (data_out !== 16'h0005) begin
            bad++; $display("FAIL ovf_cleared got=%h want=0005", data_out);
        end
        mem_read = 1'b0;
        for (int g = 5; g < 5 * FRAME; g++) begin
            total++;
            if (tx !== exp_tx(bytes[g / FRAME], g % FRAME)) begin
                bad++; $display("FAIL ovf_tx g=%0d got=%b want=%b", g, tx, exp_tx(bytes[g / FRAME], g % FRAME));
            end
            wait_slot();
        end
        for (int i = 0; i < 2 * CPB; i++) begin
            total++;
            if (tx !== 1'b1) begin
                bad++; $display("FAIL ovf_dropped_sent cyc=%0d got=%b want=1", i, tx);
            end
            wait_slot();
        end
        mem_read = 1'b1;
        #1;
        total++;
        if (data_out !== 16'h0002) begin
            bad++; $display("FAIL ovf_end_status got=%h want=0002", data_out);
        end
        mem_read = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        address = 16'hFF00; mem_write = 1'b1;
        data_in = 8'h55; wait_slot();
        data_in = 8'h66; wait_slot();
        data_in = 8'h77; wait_slot();
        mem_write = 1'b0;
        // Frame of 8'h55 is at cycle 1; move into DATA bit 3 (cycles 16..19).
        for (int g = 1; g < 17; g++) wait_slot();
        total++;
        if (tx !== 1'b0) begin
            bad++; $display("FAIL pre_reset_bit3 got=%b want=0", tx);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (tx !== 1'b1) begin
            bad++; $display("FAIL async_reset_tx got=%b want=1", tx);
        end
        address = 16'hFF01; mem_read = 1'b1;
        #1;
        total++;
        if (data_out !== 16'h0002) begin
            bad++; $display("FAIL async_reset_status got=%h want=0002", data_out);
        end
        mem_read = 1'b0;
        wait_slot();
        reset = 1'b0;
        for (int i = 0; i < FRAME + 10; i++) begin
            total++;
            if (tx !== 1'b1) begin
                bad++; $display("FAIL queue_discarded cyc=%0d got=%b want=1", i, tx);
            end
            wait_slot();
        end
        // First push after reset starts a frame one edge later.
        address = 16'hFF00; data_in = 8'h3C; mem_write = 1'b1;
        wait_slot();
        mem_write = 1'b0;
        total++;
        if (tx !== 1'b1) begin
            bad++; $display("FAIL post_reset_push_edge got=%b want=1", tx);
        end
        wait_slot();
        total++;
        if (tx !== 1'b0) begin
            bad++; $display("FAIL post_reset_start got=%b want=0", tx);
        end
        repeat (FRAME + 2) wait_slot();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_frame(8'hA5);
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
